// File: rtl/clk_2n_divider.sv
// clk_2n_divider
//   Power-of-two clock divider / periodic strobe generator. A free-running
//   n-bit counter advances on every rising edge of clockin. Its MSB is
//   the output: a 50% duty square wave with a period of 2^n clockin cycles.
//   The memory model uses it as a "data valid" strobe, so consumers should
//   treat it as a data/enable signal synchronous to clockin, not as a clock.
//
// Parameters
//   n        counter width, 1..31; division ratio is 2^n
//
// Ports
//   clockin  input   clock; all state updates on its rising edge
//   rst      input   synchronous active-high reset (clears the counter)
//   clockout output  divided clock / valid strobe, registered (glitch-free)

module clk_2n_divider #(
  parameter int n = 4
) (
  input  logic clockin,
  input  logic rst,
  output logic clockout
);

  // Reject widths that cannot form a counter or overflow the ratio.
  if (n < 1 || n > 31) begin : gen_bad_width
    $fatal(1, "clk_2n_divider: n must be in 1..31");
  end

  // Power-up value lets the output stay known even before the first reset.
  logic [n-1:0] cnt_q = '0;
  logic [n-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;  // natural wrap from 2^n-1 to 0
    if (rst) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clockin) begin
    cnt_q <= cnt_d;
  end

  // Taken straight from the flop: no logic between register and output.
  assign clockout = cnt_q[n-1];

endmodule

// File: tb/tb_clk_2n_divider.sv
// Testbench for clk_2n_divider. Three instances (n = 4, 1, 2) share one
// clock and have their own resets. A reference model tracks the number of
// non-reset edges k since the last reset edge for each instance and predicts
// clockout = (k mod 2^n) >= 2^(n-1).

module tb_clk_2n_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic out4, out1, out2;

  int k4 = 0, k1 = 0, k2 = 0;
  int checks = 0;
  int failures = 0;

  clk_2n_divider #(.n(4)) u_div4 (.clockin(clk), .rst(rst4), .clockout(out4));
  clk_2n_divider #(.n(1)) u_div1 (.clockin(clk), .rst(rst1), .clockout(out1));
  clk_2n_divider #(.n(2)) u_div2 (.clockin(clk), .rst(rst2), .clockout(out2));

  function automatic logic ref_out(int width, int k);
    return ((k % (1 << width)) >= (1 << (width - 1))) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One rising edge with the given resets, then compare every instance
  // against the model.
  task automatic tick(logic r4, logic r1, logic r2);
    @(negedge clk);
    rst4 = r4;
    rst1 = r1;
    rst2 = r2;
    @(posedge clk);
    #1;
    k4 = r4 ? 0 : k4 + 1;
    k1 = r1 ? 0 : k1 + 1;
    k2 = r2 ? 0 : k2 + 1;
    check("model_n4", out4, ref_out(4, k4));
    check("model_n1", out1, ref_out(1, k1));
    check("model_n2", out2, ref_out(2, k2));
  endtask

  initial begin
    int rises, falls, run_len, edges;
    logic prev;

    // Power-up value before any clock edge.
    #1;
    check("powerup_n4", out4, 1'b0);
    check("powerup_n1", out1, 1'b0);
    check("powerup_n2", out2, 1'b0);

    // Reset: n=4 and n=1 for 3 edges, n=2 held for 10 edges.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      check("rst_n4_low", out4, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      check("rst_hold_n2_low", out2, 1'b0);
    end
    // k4 and k1 are now 7; n=2 is just out of reset after the next edge.

    // n=2 release pattern and n=1 toggling, with n=4 continuing.
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("n2_pattern", out2, (i % 4) >= 2 ? 1'b1 : 1'b0);
      check("n1_toggle", out1, ((7 + i) % 2 == 1) ? 1'b1 : 1'b0);
    end
    // k4 is 15: the n=4 output must be high, and fall on the wrap edge.
    check("n4_before_wrap", out4, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("n4_wrap_fall", out4, 1'b0);

    // Fresh reset of n=4, then 64 free-running edges: count transitions
    // and verify every high/low interval is exactly 8 cycles.
    tick(1'b1, 1'b0, 1'b0);
    rises = 0;
    falls = 0;
    run_len = 0;
    prev = out4;
    for (int i = 1; i <= 64; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      run_len++;
      if (out4 !== prev) begin
        check("interval_len", (run_len == 8) ? 1'b1 : 1'b0, 1'b1);
        if (out4 === 1'b1) rises++;
        else falls++;
        run_len = 0;
      end
      if (i == 8) check("first_rise_k8", out4, 1'b1);
      if (i == 7) check("low_k7", out4, 1'b0);
      prev = out4;
    end
    check("rise_count", (rises == 4) ? 1'b1 : 1'b0, 1'b1);
    check("fall_count", (falls == 4) ? 1'b1 : 1'b0, 1'b1);

    // Mid-period reset while high: k=11 after a reset.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b0, 1'b0);
    check("k11_high", out4, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check("midperiod_rst_low", out4, 1'b0);
    edges = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0);
      edges++;
    end while (out4 !== 1'b1 && edges < 20);
    check("rise_after_rst_8", (edges == 8) ? 1'b1 : 1'b0, 1'b1);

    // Randomized resets on all instances, checked against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_2n_divider.md
Name: clk_2n_divider

Overview:
Synchronous power-of-two clock divider / periodic strobe generator.
- Free-running n-bit counter clocked by clockin; clockout is the counter MSB, giving a 50% duty square wave of period 2^n input cycles.
- Used by the main memory model as its "data valid" indicator (memValid1): memory output is considered valid only while clockout is high.

Parameters:
n, 4, counter width. Division ratio is 2^n. Legal range 1..31; n < 1 must cause an elaboration error (generate-time assertion).

Ports:
clockin  input  1  Clock; all state updates on its rising edge.
rst      input  1  Synchronous, active-high reset.
clockout output 1  Divided clock / valid strobe; period 2^n clockin cycles, 50% duty.

Behaviour:
- State: one n-bit unsigned register cnt. No other state.
- Every rising edge of clockin:
  - rst = 1: cnt <= 0.
  - Otherwise: cnt <= cnt + 1, modulo 2^n (wraps from 2^n-1 to 0, no saturation).
- clockout = cnt[n-1], driven directly from the flop output. No combinational logic after the register, so the output is glitch-free.
- Reset value:
  - cnt = 0, clockout = 0.
  - Output is known (0) after the first rising edge with rst = 1.
  - Before any reset, the initial register value is 0 (declared initializer).
- Timing after reset release: let k = number of rising edges with rst = 0 since the last edge with rst = 1.
  - cnt = k mod 2^n.
  - clockout = 1 exactly when (k mod 2^n) >= 2^(n-1).
  - For n = 4: low for 8 edges, high for 8 edges, repeating.
- First rising transition of clockout occurs on edge k = 2^(n-1) after reset release.
- Latency: clockout changes on the same clockin edge that updates cnt. No additional pipeline stage.
- Reset held high for multiple cycles: cnt stays 0 and clockout stays 0.
- Reset mid-period (including while clockout = 1):
  - The next rising edge forces cnt = 0 and clockout = 0.
  - The count restarts from 0 with no residual phase.
- rst is sampled only on clockin rising edges. Pulses shorter than a cycle that miss an edge have no effect.
- n = 1: clockout toggles every cycle (clockin / 2).
- Output is synchronous to clockin. It must not be used as a clock elsewhere without proper clock-domain handling; in this design it is consumed as a data/enable signal.

Test Plan:
1. n=4, rst high 3 edges then low. Required: clockout = 0 during reset and for edges 1..7; 1 for edges 8..15; 0 for edges 16..23; 1 for edges 24..31.
2. n=4, free run 64 edges after reset. Required: exactly 4 rising and 4 falling transitions of clockout; each high and low interval spans exactly 8 clockin cycles.
3. n=4, assert rst for 1 edge at k=11 (clockout = 1). Required: clockout = 0 on that edge; next rise occurs 8 edges after rst deasserts.
4. n=1, after reset. Required: clockout sequence 0,1,0,1,... toggling every edge.
5. n=2, rst held high for 10 edges. Required: clockout constantly 0. After release: pattern 0,1,1,0,0,1,1,... (rise at k=2, fall at k=4).
6. n=4, run 2^n edges. Required: counter wraps from 15 to 0 with clockout falling exactly on the wrap edge; no X on clockout after the first reset edge.
